// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_if: LOAD/STORE request/response bus between the core datapath
// (master) and the data-memory responder (slave).
//   req_valid  : core presents a word access this cycle
//   req_write  : 1 = store, 0 = load
//   req_addr   : byte address from the ALU
//   req_wdata  : store data
//   req_ready  : responder is idle and will accept a request
//   resp_valid : one-cycle completion pulse
//   resp_rdata : load data, held until the next response
//   resp_error : misaligned / out-of-range, qualified by resp_valid
//   stall      : combinational hold request for the core clock enable
// ---------------------------------------------------------------------------
interface data_mem_if;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_error;
    logic        stall;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error, stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder: memory-side end of the 16-bit core LOAD/STORE path.
// Accepts one word request at a time, inserts WAIT_CYCLES wait states and
// returns a single-cycle response with load data or an error flag.
//   clk       : clock, all state changes on the rising edge
//   reset     : synchronous, active-high reset
//   bus       : data_mem_if slave modport (request/response/stall)
//   err_count : saturating count of error responses
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int unsigned ADDR_WORDS  = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    data_mem_if.slave     bus,
    output logic [7:0]    err_count
);

    localparam int unsigned DW      = 16;
    localparam int unsigned CW      = 4;
    localparam int unsigned ECW     = 8;
    localparam int unsigned AW      = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
    localparam logic [ECW-1:0] EMAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            write_q, write_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [ECW-1:0]  err_cnt_q, err_cnt_d;
    logic            mem_we;

    logic [DW-1:0]   mem [ADDR_WORDS];

    // Transaction view: in IDLE the access being accepted is still on the
    // bus, so a zero-wait response must read from the live request.
    logic            cur_write;
    logic [DW-1:0]   cur_addr;
    logic            cur_err;
    logic [AW-1:0]   cur_idx;
    logic [DW-1:0]   rd_word;

    always_comb begin
        cur_write = (state_q == ST_IDLE) ? bus.req_write : write_q;
        cur_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
        cur_err   = cur_addr[0] | (32'(cur_addr[DW-1:1]) >= ADDR_WORDS);
        cur_idx   = cur_addr[AW:1];
        rd_word   = mem[cur_idx];
    end

    // Next-state, datapath capture and completion side effects.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        err_cnt_d = err_cnt_q;
        mem_we    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    err_d   = cur_err;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        rdata_d = (cur_write | cur_err) ? '0 : rd_word;
                    end else begin
                        wcnt_d  = CW'(WAIT_CYCLES);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q - CW'(1);
                if (wcnt_q == CW'(1)) begin
                    state_d = ST_RESP;
                    rdata_d = (cur_write | cur_err) ? '0 : rd_word;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (err_q) begin
                    if (err_cnt_q != EMAX) begin
                        err_cnt_d = err_cnt_q + ECW'(1);
                    end
                end else if (write_q) begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Store commit on the edge leaving RESP; reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[addr_q[AW:1]] <= wdata_q;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_error = (state_q == ST_RESP) & err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.stall      = bus.req_valid & ~bus.resp_valid;
    assign err_count      = err_cnt_q;

endmodule
